alu_op_issuer: RTL and testbench
================================

// Module: alu_op_issuer
// PURPOSE
//  Control-side counterpart of the ALU result mux. It accepts an ALU request
//  {alu_op, funct} over a valid/ready handshake and decodes it to the 3-bit
//  mux select. It holds that select stable while the ALU datapath settles,
//  then registers the selected mux result and returns it over a valid/ready
//  response handshake. It sits between the main control unit and the ALU
//  result mux.
// PARAMETERS
//  WIDTH          32  data width of mux_result / resp_data
//  SETTLE_CYCLES  1   cycles alu_sel is held before capture; legal range 1..15
// PORTS
//  clk           in   1      system clock; all state updates on its rising edge
//  reset         in   1      synchronous, active-high reset
//  req_valid     in   1      request present
//  req_ready     out  1      block can accept a request (high only in IDLE)
//  alu_op        in   2      00=add (ld/st), 01=sub (branch), 10=R-type, 11=reserved
//  funct         in   6      R-type function field; used only when alu_op==10
//  alu_sel       out  3      select driven to the ALU result mux (registered)
//  mux_result    in   WIDTH  selected result returned by the ALU result mux
//  resp_valid    out  1      response present; held until accepted
//  resp_ready    in   1      consumer accepts the response
//  resp_data     out  WIDTH  captured mux_result
//  resp_zero     out  1      1 when resp_data == 0 (computed from the captured value)
//  resp_illegal  out  1      request did not decode; resp_data forced to 0
//  busy          out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset (sync, active-high) forces every output and all state to its reset value,
//  whatever the current state:
//   - state = IDLE
//   - alu_sel = 000, resp_valid = 0, resp_data = 0, resp_zero = 0, resp_illegal = 0
//   - settle counter = 0
//   - a request in flight is discarded
//  Decode, evaluated at request acceptance:
//   - alu_op 00 -> sel 010 (add); alu_op 01 -> sel 011 (sub)
//   - alu_op 10 with funct 100000 -> 010 (add), 100010 -> 011 (sub),
//     100100 -> 000 (and), 100101 -> 001 (or), 101010 -> 100 (slt)
//   - alu_op 10 with any other funct, or alu_op 11 -> illegal
//   - sel codes 101, 110 and 111 are never issued
//  FSM states: IDLE, SETTLE, RESP
//   - IDLE: req_ready = 1. On req_valid:
//     - legal request: alu_sel <= decoded code, counter <= 0, go to SETTLE
//     - illegal request: alu_sel is unchanged; resp_data <= 0, resp_zero <= 1,
//       resp_illegal <= 1, resp_valid <= 1, go to RESP
//   - SETTLE: alu_sel is held.
//     - counter increments each cycle
//     - on the edge where counter == SETTLE_CYCLES-1:
//       resp_data <= mux_result, resp_zero <= ~|mux_result, resp_illegal <= 0,
//       resp_valid <= 1, go to RESP
//     - req_valid is ignored
//   - RESP: resp_valid, resp_data, resp_zero, resp_illegal and alu_sel are held.
//     - resp_valid & resp_ready: resp_valid <= 0, go to IDLE
//     - req_ready is 0, so there is no same-cycle accept; the next request is
//       taken at the earliest in the cycle after returning to IDLE
//  Latency, counted in clock edges from the accept edge to resp_valid high:
//   - legal request: 1 + SETTLE_CYCLES (2 with the default)
//   - illegal request: 1
//  Throughput: one request per (latency + 1) cycles at best.
//  Width rules:
//   - resp_data is mux_result unmodified
//   - resp_zero is the NOR reduction over all WIDTH bits
//  Boundary conditions:
//   - resp_ready held high in RESP: response accepted in its first cycle
//   - resp_ready low indefinitely: outputs stay stable and no request is accepted
//   - reset asserted together with req_valid: reset wins; the request is not accepted
//   - alu_sel changes only on a legal accept or on reset, never during SETTLE or RESP
//   - mux_result is sampled only on the capture edge; changes at other times are ignored
// TESTING
//  1. Reset: assert reset for 2 cycles -> alu_sel=000, resp_valid=0, req_ready=1, busy=0.
//  2. R-type add: alu_op=10, funct=100000, mux model returns 0x0000_0005
//     -> alu_sel=010 one edge after accept; resp_valid high 2 edges after accept;
//     resp_data=0x5, resp_zero=0.
//  3. Branch sub giving zero: alu_op=01, mux_result=0 -> alu_sel=011, resp_zero=1;
//     hold resp_ready=0 for 5 cycles -> outputs stable and req_ready=0 throughout.
//  4. Illegal: alu_op=10, funct=100110 (xor) -> resp_valid 1 edge after accept,
//     resp_illegal=1, resp_data=0, alu_sel keeps its previous value.
//  5. Reset mid-op: accept slt (funct 101010), assert reset during SETTLE
//     -> no response; state=IDLE, alu_sel=000 the next cycle.
//  6. Back-to-back: and (100100) then or (100101) with resp_ready=1 and
//     SETTLE_CYCLES=3 -> sel 000 then 001; second accept occurs 5 edges after the first.

Source files
------------

// File: rtl/alu_op_issuer.sv
// Decodes {alu_op, funct} to the ALU result mux select and holds it while the datapath settles.
// It then captures the mux result and returns it over a valid/ready response handshake.
module alu_op_issuer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] mux_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             resp_illegal,
  output logic             busy
);

  // state  | meaning
  // IDLE   | waiting for a request, req_ready high
  // SETTLE | alu_sel held while the ALU datapath settles
  // RESP   | response presented until the consumer takes it
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [2:0] dec_sel;
  logic       dec_legal;
  logic       settle_done;

  assign settle_done = (cnt == 4'(SETTLE_CYCLES - 1));

  always_comb begin
    dec_sel   = 3'b000;
    dec_legal = 1'b1;
    case (alu_op)
      2'b00: dec_sel = 3'b010;
      2'b01: dec_sel = 3'b011;
      2'b10: begin
        case (funct)
          6'b100000: dec_sel = 3'b010;
          6'b100010: dec_sel = 3'b011;
          6'b100100: dec_sel = 3'b000;
          6'b100101: dec_sel = 3'b001;
          6'b101010: dec_sel = 3'b100;
          default:   dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = dec_legal ? SETTLE : RESP;
      SETTLE:  if (settle_done) state_nxt = RESP;
      RESP:    if (resp_valid && resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // Select, counter and response registers; held unless the FSM is at an update point.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_sel      <= 3'b000;
      cnt          <= 4'd0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_zero    <= 1'b0;
      resp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (dec_legal) begin
              alu_sel <= dec_sel;
              cnt     <= 4'd0;
            end else begin
              resp_data    <= '0;
              resp_zero    <= 1'b1;
              resp_illegal <= 1'b1;
              resp_valid   <= 1'b1;
            end
          end
        end
        SETTLE: begin
          cnt <= cnt + 4'd1;
          if (settle_done) begin
            resp_data    <= mux_result;
            resp_zero    <= ~|mux_result;
            resp_illegal <= 1'b0;
            resp_valid   <= 1'b1;
          end
        end
        RESP: begin
          if (resp_valid && resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer: a decode/latency vector table on a default instance,
// plus hand-written hold, reset and back-to-back sequences (the latter on a SETTLE_CYCLES=3 instance).
module tb_alu_op_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_zero, resp_illegal, busy;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [2:0]  alu_sel;
  logic [31:0] mux_result, resp_data;

  logic        req_valid3, req_ready3, resp_valid3, resp_ready3, resp_zero3, resp_illegal3, busy3;
  logic [1:0]  alu_op3;
  logic [5:0]  funct3;
  logic [2:0]  alu_sel3;
  logic [31:0] mux3, resp_data3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_op_issuer #(.WIDTH(32), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .alu_op(alu_op), .funct(funct), .alu_sel(alu_sel), .mux_result(mux_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_illegal(resp_illegal), .busy(busy)
  );

  alu_op_issuer #(.WIDTH(32), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .alu_op(alu_op3), .funct(funct3), .alu_sel(alu_sel3), .mux_result(mux3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_data(resp_data3),
    .resp_zero(resp_zero3), .resp_illegal(resp_illegal3), .busy(busy3)
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] mux;
    logic [2:0]  sel;
    logic        ill;
    logic [31:0] data;
    logic        zero;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    int resp_n;
    int sel_n;
    logic [31:0] hold_data;

    vecs[0] = '{2'b10, 6'b100000, 32'h0000_0005, 3'b010, 1'b0, 32'h0000_0005, 1'b0};
    vecs[1] = '{2'b01, 6'b000000, 32'h0000_0000, 3'b011, 1'b0, 32'h0000_0000, 1'b1};
    vecs[2] = '{2'b00, 6'b111111, 32'hFFFF_FFFF, 3'b010, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{2'b10, 6'b100100, 32'h8000_0000, 3'b000, 1'b0, 32'h8000_0000, 1'b0};
    vecs[4] = '{2'b10, 6'b100110, 32'h0000_1234, 3'b000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[5] = '{2'b10, 6'b100101, 32'h0000_0001, 3'b001, 1'b0, 32'h0000_0001, 1'b0};
    vecs[6] = '{2'b11, 6'b100000, 32'h0000_0007, 3'b001, 1'b1, 32'h0000_0000, 1'b1};
    vecs[7] = '{2'b10, 6'b101010, 32'h0000_0001, 3'b100, 1'b0, 32'h0000_0001, 1'b0};
    vecs[8] = '{2'b10, 6'b100010, 32'h0000_0000, 3'b011, 1'b0, 32'h0000_0000, 1'b1};
    vecs[9] = '{2'b10, 6'b000000, 32'h0000_0009, 3'b011, 1'b1, 32'h0000_0000, 1'b1};

    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; alu_op = 2'b00; funct = 6'd0;
    mux_result = 32'd0;
    req_valid3 = 1'b0; resp_ready3 = 1'b0; alu_op3 = 2'b00; funct3 = 6'd0; mux3 = 32'd0;

    // Reset for two cycles.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_sel", 32'(alu_sel), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_zero", 32'(resp_zero), 32'd0);

    // Decode / latency table.
    foreach (vecs[i]) begin
      check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'd1);
      req_valid = 1'b1; alu_op = vecs[i].op; funct = vecs[i].fn; mux_result = vecs[i].mux;
      n = 0;
      resp_n = 0;
      while (n < 10 && resp_n == 0) begin
        @(negedge clk);
        n++;
        req_valid = 1'b0;
        if (n == 1 && !vecs[i].ill) check($sformatf("v%0d_sel_1edge", i), 32'(alu_sel), 32'(vecs[i].sel));
        if (resp_valid) resp_n = n;
      end
      check($sformatf("v%0d_latency", i), resp_n, vecs[i].ill ? 1 : 2);
      check($sformatf("v%0d_sel", i), 32'(alu_sel), 32'(vecs[i].sel));
      check($sformatf("v%0d_data", i), resp_data, vecs[i].data);
      check($sformatf("v%0d_zero", i), 32'(resp_zero), 32'(vecs[i].zero));
      check($sformatf("v%0d_illegal", i), 32'(resp_illegal), 32'(vecs[i].ill));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check($sformatf("v%0d_valid_drop", i), 32'(resp_valid), 32'd0);
    end

    // Branch sub giving zero, consumer stalls for 5 cycles.
    alu_op = 2'b01; funct = 6'd0; mux_result = 32'd0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("hold_valid0", 32'(resp_valid), 32'd1);
    check("hold_zero0", 32'(resp_zero), 32'd1);
    hold_data = resp_data;
    for (int k = 0; k < 5; k++) begin
      mux_result = 32'hDEAD_0000 + 32'(k);
      req_valid = 1'b1; alu_op = 2'b10; funct = 6'b100101;
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_sel", 32'(alu_sel), 32'b011);
      check("hold_data", resp_data, hold_data);
      check("hold_zero", 32'(resp_zero), 32'd1);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("hold_release", 32'(req_ready), 32'd1);

    // Reset during SETTLE discards the slt request.
    alu_op = 2'b10; funct = 6'b101010; mux_result = 32'd1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst_sel_pre", 32'(alu_sel), 32'b100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_valid", 32'(resp_valid), 32'd0);
    check("midrst_sel", 32'(alu_sel), 32'd0);
    check("midrst_idle", 32'(req_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);

    // Reset together with req_valid: reset wins.
    reset = 1'b1; req_valid = 1'b1; alu_op = 2'b00;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    check("rstreq_busy", 32'(busy), 32'd0);
    check("rstreq_sel", 32'(alu_sel), 32'd0);
    check("rstreq_valid", 32'(resp_valid), 32'd0);

    // Back-to-back and/or on SETTLE_CYCLES=3; mux3 is 0x0F only at the first capture edge.
    req_valid3 = 1'b1; resp_ready3 = 1'b1; alu_op3 = 2'b10; funct3 = 6'b100100; mux3 = 32'hAA;
    n = 0; resp_n = 0; sel_n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("b2b_sel_and", 32'(alu_sel3), 32'b000);
        check("b2b_busy", 32'(busy3), 32'd1);
        funct3 = 6'b100101;
      end
      mux3 = (n == 3) ? 32'h0F : 32'hAA;
      if (resp_valid3 && resp_n == 0) begin
        resp_n = n;
        check("b2b_data1", resp_data3, 32'h0F);
        check("b2b_zero1", 32'(resp_zero3), 32'd0);
      end
      if (alu_sel3 == 3'b001 && sel_n == 0) begin
        sel_n = n;
        req_valid3 = 1'b0;
      end
      if (sel_n != 0 && n == sel_n + 3) begin
        check("b2b_valid2", 32'(resp_valid3), 32'd1);
        check("b2b_data2", resp_data3, 32'hAA);
      end
    end
    check("b2b_latency", resp_n, 4);
    check("b2b_second_accept", sel_n, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
